sl_transmitter: RTL and testbench

Serial-line (SL) transmitter: accepts a data word and a configuration over the register interface and drives it onto the two-wire SL bus. SL0 carries zeros and SL1 carries ones. Each frame carries the data bits, a per-line parity phase and a stop condition. It is the far end of `SL_receiver`: a frame sent here with matching configuration is received there with `status_w == 16'b1000` and identical `data_w`. It has a one-word holding buffer so frames can be sent back-to-back.

---
 rtl/sl_transmitter_if.sv | 29 ++
 rtl/sl_transmitter.sv | 217 +++++++++++++++++++++
 tb/tb_sl_transmitter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sl_transmitter_if.sv
// sl_transmitter_if
// Register-side bus and the two SL line outputs of the serial-line transmitter.
//   wr_config_w / wr_enable  : config word and its one-cycle write strobe
//   r_config_w               : current config register
//   data_w / data_wr_en      : data word and its one-cycle write strobe
//   status_w                 : {11'b0, overrun, done, config error, buffer full, busy}
//   serial_line_zeroes_a     : SL0, idle high, pulled low for 0-bits
//   serial_line_ones_a       : SL1, idle high, pulled low for 1-bits
// master = the host driving writes, slave = the transmitter.
interface sl_transmitter_if;
  logic [15:0] wr_config_w;
  logic        wr_enable;
  logic [15:0] r_config_w;
  logic [31:0] data_w;
  logic        data_wr_en;
  logic [15:0] status_w;
  logic        serial_line_zeroes_a;
  logic        serial_line_ones_a;

  modport master (
    output wr_config_w, wr_enable, data_w, data_wr_en,
    input  r_config_w, status_w, serial_line_zeroes_a, serial_line_ones_a
  );

  modport slave (
    input  wr_config_w, wr_enable, data_w, data_wr_en,
    output r_config_w, status_w, serial_line_zeroes_a, serial_line_ones_a
  );
endinterface

// File: rtl/sl_transmitter.sv
// sl_transmitter
// Serial-line transmitter. Takes a data word and a config word from the register
// bus and sends the low N bits LSB first on the two-wire SL bus, followed by a
// per-line parity phase and a stop condition. A one-word holding buffer lets the
// host queue the next frame while the current one is still on the wire.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : sl_transmitter_if.slave (register bus + SL0/SL1 outputs)
// Parameters:
//   HALF_CYCLES    : half-unit H in clk cycles (>= 1)
//   DEFAULT_CONFIG : config register value after reset
module sl_transmitter #(
  parameter int          HALF_CYCLES    = 16,
  parameter logic [15:0] DEFAULT_CONFIG = 16'h0040
) (
  input logic             clk,
  input logic             rst_n,
  sl_transmitter_if.slave bus
);

  localparam int            PW        = $clog2(2 * HALF_CYCLES) + 1;
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0] FULL_LAST = PW'(2 * HALF_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    BIT_PRE,
    BIT_LOW,
    BIT_POST,
    PAR_PRE,
    PAR,
    GAP,
    STOP,
    END
  } state_t;

  state_t        state;
  logic [PW-1:0] phaseCnt;
  logic [5:0]    bitCnt;
  logic [31:0]   shiftReg;
  logic [5:0]    frameLen;
  logic          framePce;
  logic          parZero;
  logic          parOne;
  logic [31:0]   bufData;
  logic          bufFull;
  logic          doneFlag;
  logic          overrunFlag;
  logic          cfgErr;
  logic [15:0]   configReg;
  logic          sl0Reg;
  logic          sl1Reg;

  logic          longPhase;
  logic          phaseDone;
  logic          drain;
  logic          wrAccept;
  logic [5:0]    cfgLen;
  logic          cfgValid;

  // Phase bookkeeping and buffer handshake. The buffer is drained into the
  // shifter when a frame starts: from IDLE, or straight out of END so that
  // queued frames follow each other with no idle cycle. A write that lands on
  // the draining edge is accepted because the slot frees up on that same edge.
  always_comb begin
    longPhase = (state == BIT_LOW) || (state == PAR) || (state == GAP) || (state == STOP);
    phaseDone = (phaseCnt == (longPhase ? FULL_LAST : HALF_LAST));
    drain     = bufFull && ((state == IDLE) || ((state == END) && phaseDone));
    wrAccept  = bus.data_wr_en && (!bufFull || drain);
    cfgLen    = bus.wr_config_w[6:1];
    cfgValid  = (cfgLen >= 6'd8) && (cfgLen <= 6'd32);
  end

  // Config register: only frame lengths 8..32 are taken; anything else leaves
  // the register alone and raises the config-error flag until the next good write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      configReg <= DEFAULT_CONFIG;
      cfgErr    <= 1'b0;
    end else if (bus.wr_enable) begin
      if (cfgValid) begin
        configReg <= bus.wr_config_w;
        cfgErr    <= 1'b0;
      end else begin
        cfgErr <= 1'b1;
      end
    end
  end

  // Frame FSM, holding buffer and sticky status flags. Line levels are set on
  // the edge that enters each state so both SL outputs come straight from flops.
  // The config and data word are copied into the frame registers on the drain
  // edge, so config writes during a frame only affect later frames.
  // Parity: parZero starts at 1 and flips on every 0-bit, parOne starts at 0 and
  // flips on every 1-bit; both are updated as each bit's low level begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      phaseCnt    <= '0;
      bitCnt      <= '0;
      shiftReg    <= '0;
      frameLen    <= '0;
      framePce    <= 1'b0;
      parZero     <= 1'b1;
      parOne      <= 1'b0;
      bufData     <= '0;
      bufFull     <= 1'b0;
      doneFlag    <= 1'b0;
      overrunFlag <= 1'b0;
      sl0Reg      <= 1'b1;
      sl1Reg      <= 1'b1;
    end else begin
      if ((state == END) && phaseDone && !bufFull) begin
        doneFlag <= 1'b1;
      end

      if (wrAccept) begin
        bufData  <= bus.data_w;
        bufFull  <= 1'b1;
        doneFlag <= 1'b0;
        if (!bufFull) begin
          overrunFlag <= 1'b0;
        end
      end else begin
        if (drain) begin
          bufFull <= 1'b0;
        end
        if (bus.data_wr_en) begin
          overrunFlag <= 1'b1;
        end
      end

      if (drain) begin
        shiftReg <= bufData;
        frameLen <= configReg[6:1];
        framePce <= configReg[0];
        bitCnt   <= '0;
        parZero  <= 1'b1;
        parOne   <= 1'b0;
      end

      if (state == IDLE) begin
        phaseCnt <= '0;
        if (bufFull) begin
          state <= BIT_PRE;
        end
      end else if (!phaseDone) begin
        phaseCnt <= phaseCnt + PW'(1);
      end else begin
        phaseCnt <= '0;
        case (state)
          BIT_PRE: begin
            state <= BIT_LOW;
            if (shiftReg[0]) begin
              sl1Reg <= 1'b0;
              parOne <= ~parOne;
            end else begin
              sl0Reg  <= 1'b0;
              parZero <= ~parZero;
            end
          end
          BIT_LOW: begin
            state  <= BIT_POST;
            sl0Reg <= 1'b1;
            sl1Reg <= 1'b1;
          end
          BIT_POST: begin
            shiftReg <= {1'b0, shiftReg[31:1]};
            if (bitCnt < (frameLen - 6'd1)) begin
              bitCnt <= bitCnt + 6'd1;
              state  <= BIT_PRE;
            end else begin
              state <= PAR_PRE;
            end
          end
          PAR_PRE: begin
            state <= PAR;
            if (framePce) begin
              sl0Reg <= parZero;
              sl1Reg <= parOne;
            end
          end
          PAR: begin
            state  <= GAP;
            sl0Reg <= 1'b1;
            sl1Reg <= 1'b1;
          end
          GAP: begin
            state  <= STOP;
            sl0Reg <= 1'b0;
            sl1Reg <= 1'b0;
          end
          STOP: begin
            state  <= END;
            sl0Reg <= 1'b1;
            sl1Reg <= 1'b1;
          end
          END: begin
            state <= bufFull ? BIT_PRE : IDLE;
          end
          default: begin
            state  <= IDLE;
            sl0Reg <= 1'b1;
            sl1Reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.r_config_w           = configReg;
  assign bus.status_w             = {11'b0, overrunFlag, doneFlag, cfgErr, bufFull, (state != IDLE)};
  assign bus.serial_line_zeroes_a = sl0Reg;
  assign bus.serial_line_ones_a   = sl1Reg;

endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter
// Testbench for sl_transmitter with H=16. Each frame's SL0/SL1 waveform is
// compared cycle by cycle against a reference computed from the frame rules
// (bit slots of 4H, parity from bit counts, fixed trailer), plus status and
// config register checks around each scenario.
module tb_sl_transmitter;

  localparam int H = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sl_transmitter_if bus ();

  sl_transmitter #(
    .HALF_CYCLES   (H),
    .DEFAULT_CONFIG(16'h0040)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {SL0, SL1} at cycle idx of a frame (idx 0 = first BIT_PRE cycle).
  function automatic logic [1:0] modelLines(input logic [31:0] d, input int n,
                                            input bit pce, input int idx);
    int ones;
    int zeros;
    int r;
    int off;
    logic p0;
    logic p1;
    ones = 0;
    for (int k = 0; k < n; k++) ones += int'(d[k]);
    zeros = n - ones;
    p0 = (zeros % 2 == 0) ? 1'b1 : 1'b0;
    p1 = (ones % 2 == 1) ? 1'b1 : 1'b0;
    if (idx < 4 * H * n) begin
      off = idx % (4 * H);
      if (off < H || off >= 3 * H) return 2'b11;
      return d[idx / (4 * H)] ? 2'b10 : 2'b01;
    end
    r = idx - 4 * H * n;
    if (r < H)     return 2'b11;
    if (r < 3 * H) return pce ? {p0, p1} : 2'b11;
    if (r < 5 * H) return 2'b11;
    if (r < 7 * H) return 2'b00;
    return 2'b11;
  endfunction

  task automatic writeConfig(input logic [15:0] cfg);
    bus.wr_config_w = cfg;
    bus.wr_enable   = 1'b1;
    @(negedge clk);
    bus.wr_enable   = 1'b0;
  endtask

  task automatic writeData(input logic [31:0] d);
    bus.data_w     = d;
    bus.data_wr_en = 1'b1;
    @(negedge clk);
    bus.data_wr_en = 1'b0;
  endtask

  // Samples one whole frame starting at the current falling edge. Optional data
  // writes are injected at sample indices idxB / idxC, and status is captured on
  // the sample after each injection. Ends on the sample after the frame's END.
  task automatic runFrame(input logic [31:0] d, input int n, input bit pce,
                          input int idxB, input logic [31:0] dB,
                          input int idxC, input logic [31:0] dC,
                          output int mism, output int firstBad,
                          output logic [1:0] parObs, output logic [1:0] stopObs,
                          output logic [15:0] statB, output logic [15:0] statC);
    int len;
    logic [1:0] obs;
    logic [1:0] expv;
    len      = 4 * H * n + 8 * H;
    mism     = 0;
    firstBad = -1;
    parObs   = 2'bxx;
    stopObs  = 2'bxx;
    statB    = 16'hxxxx;
    statC    = 16'hxxxx;
    for (int i = 0; i < len; i++) begin
      bus.data_wr_en = 1'b0;
      obs  = {bus.serial_line_zeroes_a, bus.serial_line_ones_a};
      expv = modelLines(d, n, pce, i);
      if (obs !== expv) begin
        if (mism == 0) firstBad = i;
        mism++;
      end
      if (i == 4 * H * n + 2 * H) parObs = obs;
      if (i == 4 * H * n + 6 * H) stopObs = obs;
      if (i == idxB + 1) statB = bus.status_w;
      if (i == idxC + 1) statC = bus.status_w;
      if (i == idxB) begin
        bus.data_w     = dB;
        bus.data_wr_en = 1'b1;
      end
      if (i == idxC) begin
        bus.data_w     = dC;
        bus.data_wr_en = 1'b1;
      end
      @(negedge clk);
    end
    bus.data_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.serial_line_zeroes_a, bus.serial_line_ones_a} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL resetLines: got %b expected 11", {bus.serial_line_zeroes_a, bus.serial_line_ones_a});
    end
    checks++;
    if (bus.status_w !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL resetStatus: got %h expected 0000", bus.status_w);
    end
    checks++;
    if (bus.r_config_w !== 16'h0040) begin
      failures++;
      $display("[TB] FAIL resetConfig: got %h expected 0040", bus.r_config_w);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One frame from an idle transmitter: config, write, latency, waveform, done.
  task automatic test_frame(input string name, input logic [15:0] cfg,
                            input logic [31:0] d, input logic [15:0] expStatAfterCfg);
    int n;
    bit pce;
    int mism;
    int firstBad;
    logic [1:0] parObs;
    logic [1:0] stopObs;
    logic [15:0] sB;
    logic [15:0] sC;
    n   = int'(cfg[6:1]);
    pce = cfg[0];
    writeConfig(cfg);
    checks++;
    if (bus.r_config_w !== cfg) begin
      failures++;
      $display("[TB] FAIL %s config: got %h expected %h", name, bus.r_config_w, cfg);
    end
    checks++;
    if (bus.status_w !== expStatAfterCfg) begin
      failures++;
      $display("[TB] FAIL %s statusAfterCfg: got %h expected %h", name, bus.status_w, expStatAfterCfg);
    end
    writeData(d);
    checks++;
    if (bus.status_w !== 16'h0002) begin
      failures++;
      $display("[TB] FAIL %s bufferFull: got %h expected 0002", name, bus.status_w);
    end
    @(negedge clk);
    checks++;
    if (bus.status_w !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL %s busyAtStart: got %h expected 0001", name, bus.status_w);
    end
    runFrame(d, n, pce, -1, 32'h0, -1, 32'h0, mism, firstBad, parObs, stopObs, sB, sC);
    checks++;
    if (mism !== 0) begin
      failures++;
      $display("[TB] FAIL %s waveform: got %0d bad cycles (first at %0d) expected 0", name, mism, firstBad);
    end
    checks++;
    if (parObs !== (pce ? modelLines(d, n, pce, 4 * H * n + 2 * H) : 2'b11)) begin
      failures++;
      $display("[TB] FAIL %s parity: got %b", name, parObs);
    end
    checks++;
    if (stopObs !== 2'b00) begin
      failures++;
      $display("[TB] FAIL %s stop: got %b expected 00", name, stopObs);
    end
    checks++;
    if (bus.status_w !== 16'h0008) begin
      failures++;
      $display("[TB] FAIL %s doneStatus: got %h expected 0008", name, bus.status_w);
    end
  endtask

  task automatic test_single_parity();
    logic [1:0] expPar;
    expPar = modelLines(32'h2A5, 10, 1'b1, 4 * H * 10 + 2 * H);
    checks++;
    if (expPar !== 2'b01) begin
      failures++;
      $display("[TB] FAIL modelParity: got %b expected 01", expPar);
    end
    test_frame("singleParity", 16'h0015, 32'h0000_02A5, 16'h0000);
  endtask

  task automatic test_no_parity();
    test_frame("noParity", 16'h0014, 32'h0000_02A5, 16'h0008);
  endtask

  task automatic test_random_frames();
    int n;
    bit pce;
    logic [5:0] n6;
    for (int it = 0; it < 4; it++) begin
      n   = (it == 0) ? 8 : (it == 1) ? 32 : int'($urandom_range(8, 32));
      pce = 1'($urandom_range(0, 1));
      n6  = n[5:0];
      test_frame("randomFrame", {9'd0, n6, pce}, $urandom, 16'h0008);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [5:0] n6;
    logic [15:0] cfg;
    logic [31:0] dA;
    logic [31:0] dB;
    logic [31:0] dC;
    int mism;
    int firstBad;
    logic [1:0] parObs;
    logic [1:0] stopObs;
    logic [15:0] sB;
    logic [15:0] sC;
    n   = int'($urandom_range(8, 12));
    n6  = n[5:0];
    cfg = {9'd0, n6, 1'b1};
    dA  = $urandom;
    dB  = $urandom;
    dC  = $urandom;
    writeConfig(cfg);
    writeData(dA);
    @(negedge clk);
    runFrame(dA, n, 1'b1, 100, dB, 200, dC, mism, firstBad, parObs, stopObs, sB, sC);
    checks++;
    if (mism !== 0) begin
      failures++;
      $display("[TB] FAIL b2bFrameA: got %0d bad cycles (first at %0d) expected 0", mism, firstBad);
    end
    checks++;
    if (sB !== 16'h0003) begin
      failures++;
      $display("[TB] FAIL b2bPending: got %h expected 0003", sB);
    end
    checks++;
    if (sC !== 16'h0013) begin
      failures++;
      $display("[TB] FAIL b2bOverrun: got %h expected 0013", sC);
    end
    runFrame(dB, n, 1'b1, -1, 32'h0, -1, 32'h0, mism, firstBad, parObs, stopObs, sB, sC);
    checks++;
    if (mism !== 0) begin
      failures++;
      $display("[TB] FAIL b2bFrameB: got %0d bad cycles (first at %0d) expected 0", mism, firstBad);
    end
    checks++;
    if (sB !== 16'h0011) begin
      failures++;
      $display("[TB] FAIL b2bStartB: got %h expected 0011", sB);
    end
    checks++;
    if (bus.status_w !== 16'h0018) begin
      failures++;
      $display("[TB] FAIL b2bDone: got %h expected 0018", bus.status_w);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (bus.status_w !== 16'h0018 ||
        {bus.serial_line_zeroes_a, bus.serial_line_ones_a} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL b2bNoThirdFrame: got status %h lines %b expected 0018 11",
               bus.status_w, {bus.serial_line_zeroes_a, bus.serial_line_ones_a});
    end
  endtask

  task automatic test_invalid_config();
    logic [15:0] lastCfg;
    logic [5:0] badN;
    lastCfg = bus.status_w; // overwritten below; keeps variable defined
    lastCfg = 16'h0000;
    writeConfig(16'h0010);  // N=8, lowest valid length
    lastCfg = 16'h0010;
    checks++;
    if (bus.r_config_w !== lastCfg || bus.status_w[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cfgMinValid: got %h err %b expected %h err 0", bus.r_config_w, bus.status_w[2], lastCfg);
    end
    writeConfig(16'h0003);
    checks++;
    if (bus.r_config_w !== lastCfg) begin
      failures++;
      $display("[TB] FAIL cfgBadKeep: got %h expected %h", bus.r_config_w, lastCfg);
    end
    checks++;
    if (bus.status_w !== 16'h001C) begin
      failures++;
      $display("[TB] FAIL cfgBadErr: got %h expected 001c", bus.status_w);
    end
    badN = 6'($urandom_range(33, 63));
    writeConfig({9'd0, badN, 1'b1});
    checks++;
    if (bus.r_config_w !== lastCfg || bus.status_w[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cfgTooLong: got %h err %b expected %h err 1", bus.r_config_w, bus.status_w[2], lastCfg);
    end
    writeConfig(16'h000E);  // N=7
    checks++;
    if (bus.r_config_w !== lastCfg || bus.status_w[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cfgSeven: got %h err %b expected %h err 1", bus.r_config_w, bus.status_w[2], lastCfg);
    end
    writeConfig(16'h0041);
    checks++;
    if (bus.r_config_w !== 16'h0041) begin
      failures++;
      $display("[TB] FAIL cfgRecover: got %h expected 0041", bus.r_config_w);
    end
    checks++;
    if (bus.status_w !== 16'h0018) begin
      failures++;
      $display("[TB] FAIL cfgErrClear: got %h expected 0018", bus.status_w);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    logic [1:0] expLow;
    d = $urandom;
    writeData(d);
    @(negedge clk);
    repeat (H + 4) @(negedge clk);
    expLow = modelLines(d, 32, 1'b1, H + 4);
    checks++;
    if ({bus.serial_line_zeroes_a, bus.serial_line_ones_a} !== expLow) begin
      failures++;
      $display("[TB] FAIL midFrameLow: got %b expected %b",
               {bus.serial_line_zeroes_a, bus.serial_line_ones_a}, expLow);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.serial_line_zeroes_a, bus.serial_line_ones_a} !== 2'b11 || bus.status_w !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL midReset: got lines %b status %h expected 11 0000",
               {bus.serial_line_zeroes_a, bus.serial_line_ones_a}, bus.status_w);
    end
    checks++;
    if (bus.r_config_w !== 16'h0040) begin
      failures++;
      $display("[TB] FAIL midResetConfig: got %h expected 0040", bus.r_config_w);
    end
    rst_n = 1'b1;
    test_frame("afterReset", 16'h0040, $urandom, 16'h0000);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.wr_config_w = 16'h0000;
    bus.wr_enable   = 1'b0;
    bus.data_w      = 32'h0;
    bus.data_wr_en  = 1'b0;
    @(negedge clk);
    $display("[TB] starting");
    test_reset();
    test_single_parity();
    test_no_parity();
    test_random_frames();
    test_back_to_back();
    test_invalid_config();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
